// File: rtl/spin_speed_ramp_ctrl_if.sv
// spin_speed_ramp_ctrl_if: front-panel and motor-command signals of the spin-speed ramp controller
interface spin_speed_ramp_ctrl_if #(
  parameter int SPEED_W = 11
);
  logic [2:0]         wash_mode;
  logic               load_mode;
  logic               inc;
  logic               dec;
  logic               lock;
  logic               spin_en;
  logic [3:0]         selected_level;
  logic [SPEED_W-1:0] selected_speed;
  logic [SPEED_W-1:0] motor_speed;
  logic               ramping;
  logic               at_speed;
  modport master (
    output wash_mode, load_mode, inc, dec, lock, spin_en,
    input  selected_level, selected_speed, motor_speed, ramping, at_speed
  );
  modport slave (
    input  wash_mode, load_mode, inc, dec, lock, spin_en,
    output selected_level, selected_speed, motor_speed, ramping, at_speed
  );
endinterface

// File: rtl/spin_speed_ramp_ctrl.sv
// spin_speed_ramp_ctrl: per-mode spin level selector with a rate-limited motor speed ramp
module spin_speed_ramp_ctrl #(
  parameter int          SPEED_W          = 11,
  parameter int          NUM_LEVELS       = 6,
  parameter int          SPEED_MIN        = 400,
  parameter int          SPEED_STEP       = 200,
  parameter logic [31:0] MODE_DEFAULT_LVL = 32'h52052455,
  parameter logic [31:0] MODE_MAX_LVL     = 32'h52153455,
  parameter int          RAMP_DIV         = 4,
  parameter int          RAMP_STEP        = 150
) (
  input logic                   clk,
  input logic                   reset_n,
  spin_speed_ramp_ctrl_if.slave bus
);
  localparam int               PW      = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam logic [3:0]       LVL_TOP = 4'(NUM_LEVELS - 1);
  localparam logic [PW-1:0]    PRE_TOP = PW'(RAMP_DIV - 1);
  localparam logic [SPEED_W:0] STEP_X  = (SPEED_W + 1)'(RAMP_STEP);

  if ((SPEED_MIN + (NUM_LEVELS - 1) * SPEED_STEP) >= (1 << SPEED_W) ||
      NUM_LEVELS < 2 || NUM_LEVELS > 16 || RAMP_DIV < 1) begin : g_bad_params
    $error("spin_speed_ramp_ctrl: top speed exceeds SPEED_W or level/divider parameters out of range");
  end

  logic [3:0]         r_level;
  logic               r_init;
  logic               r_inc_prev;
  logic               r_dec_prev;
  logic [PW-1:0]      r_pre;
  logic [SPEED_W-1:0] r_motor;

  logic [3:0]         w_max_raw, w_dflt_raw, w_max, w_dflt;
  logic               w_inc_rise, w_dec_rise, w_tick;
  logic [SPEED_W-1:0] w_speed, w_target, w_up, w_dn, w_next;

  assign w_max_raw  = MODE_MAX_LVL[{bus.wash_mode, 2'b00} +: 4];
  assign w_dflt_raw = MODE_DEFAULT_LVL[{bus.wash_mode, 2'b00} +: 4];
  assign w_max      = w_max_raw > LVL_TOP ? LVL_TOP : w_max_raw;
  assign w_dflt     = w_dflt_raw > w_max ? w_max : w_dflt_raw;
  assign w_inc_rise = bus.inc & ~r_inc_prev;
  assign w_dec_rise = bus.dec & ~r_dec_prev;
  assign w_speed    = SPEED_W'(SPEED_MIN) + SPEED_W'(r_level) * SPEED_W'(SPEED_STEP);
  assign w_target   = bus.spin_en ? w_speed : '0;
  assign w_tick     = r_pre == PRE_TOP;
  assign w_up       = w_target - r_motor;
  assign w_dn       = r_motor - w_target;

  // Step toward the target by at most RAMP_STEP, clamping on the final step so it never overshoots
  always_comb
    w_next = r_motor < w_target ? r_motor + ({1'b0, w_up} > STEP_X ? STEP_X[SPEED_W-1:0] : w_up) :
             r_motor > w_target ? r_motor - ({1'b0, w_dn} > STEP_X ? STEP_X[SPEED_W-1:0] : w_dn) :
             r_motor;

  // Level selection: load/init beats lock; simultaneous inc+dec rises cancel; both directions wrap
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_level    <= '0;
      r_init     <= 1'b1;
      r_inc_prev <= 1'b1;
      r_dec_prev <= 1'b1;
    end else begin
      r_inc_prev <= bus.inc;
      r_dec_prev <= bus.dec;
      if (r_init || bus.load_mode) begin
        r_level <= w_dflt;
        r_init  <= 1'b0;
      end else if (!bus.lock && (w_inc_rise ^ w_dec_rise))
        r_level <= w_inc_rise ? (r_level >= w_max ? 4'd0 : r_level + 4'd1)
                              : (r_level == 4'd0 ? w_max : r_level - 4'd1);
    end

  // Free-running prescaler; motor speed only moves on its wrap
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_pre   <= '0;
      r_motor <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick) r_motor <= w_next;
    end

  assign bus.selected_level = r_level;
  assign bus.selected_speed = w_speed;
  assign bus.motor_speed    = r_motor;
  assign bus.ramping        = r_motor != w_target;
  assign bus.at_speed       = bus.spin_en && r_motor == w_target;
endmodule

// File: doc/spin_speed_ramp_ctrl.md
# spin_speed_ramp_ctrl

Parametrised spin-speed selector and motor-speed ramp generator for the washing-machine controller. It holds a user-selected spin level per wash mode, with a per-mode default and cap, and bidirectional edge-detected up/down stepping. It produces a rate-limited motor speed command that ramps toward the selected speed while spinning and back to zero when spin stops. It sits between the front-panel button logic and the motor drive interface.

## Interface
- SPEED_W, 11, width of all speed values (rpm)
- NUM_LEVELS, 6, number of speed levels (2..16)
- SPEED_MIN, 400, speed of level 0
- SPEED_STEP, 200, rpm between adjacent levels; level i = SPEED_MIN + i*SPEED_STEP
- MODE_DEFAULT_LVL, 32'h52052455, per-mode default level, 4 bits per mode, mode m in bits [4m+3:4m]
- MODE_MAX_LVL, 32'h52153455, per-mode maximum level, same packing
- RAMP_DIV, 4, clock cycles per ramp tick (>=1)
- RAMP_STEP, 150, maximum rpm change per ramp tick
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wash_mode  in  3  current wash mode (0 cotton … 7 colours)
- load_mode  in  1  level pulse/level: reload default level for wash_mode
- inc  in  1  raw up request, rising-edge detected internally
- dec  in  1  raw down request, rising-edge detected internally
- lock  in  1  when high, inc/dec are ignored; load_mode still honoured
- spin_en  in  1  high = ramp toward selected speed, low = ramp toward 0
- selected_level  out  4  current level index
- selected_speed  out  SPEED_W  SPEED_MIN + selected_level*SPEED_STEP (combinational from level)
- motor_speed  out  SPEED_W  ramped speed command (registered)
- ramping  out  1  motor_speed != target
- at_speed  out  1  spin_en && motor_speed == target

## Operation
- Effective table entries: max_m = min(MODE_MAX_LVL[m], NUM_LEVELS-1); dflt_m = min(MODE_DEFAULT_LVL[m], max_m).
- Reset: level=0, init_pending=1, inc_prev=dec_prev=1 (a button held through reset never fires), motor_speed=0, prescaler=0. Outputs: selected_level=0, selected_speed=SPEED_MIN, motor_speed=0, ramping=spin_en, at_speed=0 when spin_en low.
- Level update priority per edge: (1) init_pending or load_mode → level=dflt_m(wash_mode), init_pending cleared; (2) lock high → hold; (3) inc rise and dec rise together → hold; (4) inc rise → level>=max_m ? 0 : level+1; (5) dec rise → level==0 ? max_m : level-1. Out-of-cap levels (mode changed without load) are only corrected by load or inc wrap.
- inc_prev/dec_prev update every cycle regardless of lock/load; a rise masked by lock or load is lost, not deferred.
- target = spin_en ? selected_speed : 0. Changing level or spin_en mid-ramp retargets immediately; no restart of the prescaler.
- Ramp tick when prescaler == RAMP_DIV-1 (prescaler then wraps to 0). On tick: if motor_speed < target, add min(RAMP_STEP, target-motor_speed); if greater, subtract min(RAMP_STEP, motor_speed-target); never overshoots, never underflows.
- Arithmetic in SPEED_W+1 bits; SPEED_MIN+(NUM_LEVELS-1)*SPEED_STEP must fit SPEED_W (elaboration check).

## Timing
- First active edge after reset_n release loads dflt_m; selected_level valid after that edge.
- Button rise sampled at edge k (inc=1, inc_prev=0) → selected_level/selected_speed change after edge k (1-cycle latency from the input).
- Ramp: first tick at edge RAMP_DIV after reset release; ticks every RAMP_DIV cycles thereafter; 0→T takes ceil(T/RAMP_STEP) ticks.
- ramping/at_speed combinational from motor_speed, target, spin_en.
- reset_n low mid-ramp: motor_speed forced to 0 immediately (asynchronous).

## Test plan
- Reset with wash_mode=3, release → after first edge selected_level=2, selected_speed=800; inc held high through release → no step.
- wash_mode=0, load, 1 inc pulse → level 5→0 (speed 1400→400); 1 dec pulse → level 5.
- wash_mode=5 (max 1): level 0, dec → 1, inc → 0; mode 6 without load, inc from 1 → 2, inc again → 0.
- lock=1, 3 inc pulses → level unchanged; inc and dec rising same cycle with lock=0 → unchanged; load_mode with lock=1 → default loaded.
- Mode 0 level 5, spin_en=1, RAMP_DIV=4, RAMP_STEP=150 → motor_speed 150,300,…,1350,1400 on ticks 1–10 (edges 4,8,…,40), at_speed=1 after edge 40; spin_en=0 → ramps down to 0, final step 50.
- Mid-ramp at motor_speed=600, dec to level 0 (400) → next tick 450? no: 600→450→400, stop; reset_n pulse → motor_speed=0, level reloads default.
